serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands a, b, cin valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have ports a, b  input  WIDTH  unsigned/two's-complement operands.
REQ-007 SHALL have port cin  input  1  initial carry-in.
REQ-008 SHALL have ports fa_a, fa_b, fa_cin  output  1  current bit and carry driven to the external full adder.
REQ-009 SHALL have ports fa_sum, fa_cout  input  1  combinational result returned by the external full adder.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  registered sum.
REQ-013 SHALL have port cout  output  1  registered final carry-out.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&&in_ready SHALL load a, b into shift registers, carry_q<=cin, bit counter<=0, go RUN.
REQ-016 RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q, combinationally, no register between them and the shift state.
REQ-017 RUN, each edge: sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}, a_sh/b_sh shift right by one, carry_q<=fa_cout, counter++.
REQ-018 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; out_valid rises exactly WIDTH edges after the accepting edge.
REQ-019 DONE: sum=sum_sh, cout=carry_q, held stable until out_valid&&out_ready, then go IDLE on that edge.
REQ-020 Throughput: one operation per WIDTH+2 cycles minimum with out_ready tied high; no overlap of operations.
REQ-021 in_valid in RUN or DONE SHALL be ignored, with no effect on state or outputs.
REQ-022 fa_a, fa_b, fa_cin SHALL be 0 in IDLE and DONE.
REQ-023 Counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within an operation.
REQ-024 sum/cout SHALL retain the last result in IDLE until the next DONE overwrites them.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, shift registers, carry_q, counter, sum, cout to 0; in_ready=1, out_valid=0 the cycle after.
REQ-026 Reset during RUN or DONE SHALL abandon the operation; no out_valid for it is ever produced.
REQ-027 Reset SHALL take priority over simultaneous in_valid or out_ready.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN defined: SHALL add output ovf (1 bit), registered at the DONE transition as signed overflow = carry into bit WIDTH-1 XOR fa_cout of bit WIDTH-1; 0 on reset; held in DONE/IDLE like sum.
REQ-029 Macro undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 WIDTH=8, a=8'h0F, b=8'h01, cin=0, out_ready=1 -> out_valid exactly 8 edges after accept, sum=8'h10, cout=0.
REQ-031 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
REQ-032 With SERIAL_ADD_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1; a=8'hFF, b=8'h01 -> ovf=0.
REQ-033 out_ready held low 5 cycles in DONE -> sum/cout/out_valid stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-034 rst_n low for one edge at bit 4 of a run -> IDLE, out_valid never asserted for it; next operation 8'h12+8'h34 -> 8'h46.
REQ-035 Random a, b, cin (1000 ops, random in_valid/out_ready) against reference a+b+cin -> {cout,sum} match every DONE.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: shifts operands LSB-first through an external full adder.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds only the low WIDTH-1 result bits; the top bit comes straight from fa_sum at the last step.
    logic [WIDTH-2:0] sum_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_cin     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                fa_a   = a_sh[0];
                fa_b   = b_sh[0];
                fa_cin = carry_q;
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= (sum_sh >> 1) | ((WIDTH-1)'(fa_sum) << (WIDTH - 2));
                    carry_q <= fa_cout;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum  <= {fa_sum, sum_sh};
                        cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_q is the carry into the MSB on this last step
                        ovf  <= carry_q ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
